// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: state and command encodings,
// the HALT opcode and default sizing.
package pipeline_sequencer_pkg;

  localparam int NB_OPCODE_DEF    = 6;
  localparam int NB_REG_DEF       = 5;
  localparam int NB_CYCLE_CNT_DEF = 32;
  localparam int DRAIN_CYCLES_DEF = 3;

  // Opcode that stops fetch and drains the pipeline to DONE.
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_t;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Debug command handshake: the debug side (master) offers a command code with
// a valid strobe, the sequencer (slave) reports whether it can take it.
interface pipeline_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd, output cmd_ready);
endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use comparator: the load in EX writes a register that the instruction
// in ID reads, so ID must wait one cycle. Register 0 never creates a hazard.
module pipeline_sequencer_hazard_detect #(
  parameter int NB_REG = 5
) (
  input  logic              ex_memread,
  input  logic [NB_REG-1:0] ex_rt,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  output logic              stall
);

  // Purely combinational so the forwarding logic can reuse it in the same cycle.
  always_comb begin
    stall = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller for the 5-stage pipeline. Turns debug commands into
// the global pipeline enable plus PC/IF-ID enables and flush/bubble controls,
// and drains the pipeline to DONE when HALT reaches ID.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int NB_OPCODE    = NB_OPCODE_DEF,
  parameter int NB_REG       = NB_REG_DEF,
  parameter int NB_CYCLE_CNT = NB_CYCLE_CNT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  pipeline_sequencer_if.slave     cmd_if,
  input  logic [NB_OPCODE-1:0]    i_id_opcode,
  input  logic [NB_REG-1:0]       i_id_rs,
  input  logic [NB_REG-1:0]       i_id_rt,
  input  logic                    i_id_jump,
  input  logic                    i_ex_memread,
  input  logic [NB_REG-1:0]       i_ex_rt,
  input  logic                    i_ex_branch_taken,
  output logic                    o_pipe_en,
  output logic                    o_pc_en,
  output logic                    o_if_id_en,
  output logic                    o_if_id_flush,
  output logic                    o_id_ex_bubble,
  output logic [2:0]              o_state,
  output logic                    o_done,
  output logic [NB_CYCLE_CNT-1:0] o_cycle_count
);

  localparam int NB_DRAIN = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_t                  state_reg;
  logic [NB_DRAIN-1:0]     drain_cnt_reg;
  logic [NB_CYCLE_CNT-1:0] cycle_cnt_reg;
  logic                    done_reg;

  logic stall;
  logic is_halt;
  logic halt_take;
  logic cmd_ready;
  logic cmd_accept;

  pipeline_sequencer_hazard_detect #(.NB_REG(NB_REG)) u_hazard_detect (
    .ex_memread (i_ex_memread),
    .ex_rt      (i_ex_rt),
    .id_rs      (i_id_rs),
    .id_rt      (i_id_rt),
    .stall      (stall)
  );

  assign is_halt    = (i_id_opcode == NB_OPCODE'(HALT_OPCODE));
  assign cmd_ready  = (state_reg == ST_IDLE) || (state_reg == ST_RUN) || (state_reg == ST_DONE);
  assign cmd_accept = cmd_if.cmd_valid && cmd_ready;

  // Per-cycle pipeline controls; a taken branch outranks HALT and stalls in ID
  // because the ID instruction is on the wrong path.
  always_comb begin
    o_pipe_en      = 1'b0;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    halt_take      = 1'b0;
    case (state_reg)
      ST_RUN, ST_STEP: begin
        o_pipe_en = 1'b1;
        if (i_ex_branch_taken) begin
          o_if_id_flush  = 1'b1;
          o_id_ex_bubble = 1'b1;
          o_pc_en        = 1'b1;
          o_if_id_en     = 1'b1;
        end else if (is_halt) begin
          o_id_ex_bubble = 1'b1;
          halt_take      = 1'b1;
        end else if (stall) begin
          o_id_ex_bubble = 1'b1;
        end else if (i_id_jump) begin
          o_if_id_flush = 1'b1;
          o_pc_en       = 1'b1;
          o_if_id_en    = 1'b1;
        end else begin
          o_pc_en    = 1'b1;
          o_if_id_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        o_pipe_en      = 1'b1;
        o_id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer FSM with drain countdown, done flag and saturating cycle counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= '0;
      cycle_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      if (o_pipe_en && (cycle_cnt_reg != '1)) begin
        cycle_cnt_reg <= cycle_cnt_reg + NB_CYCLE_CNT'(1);
      end
      case (state_reg)
        ST_IDLE: begin
          if (cmd_accept && (cmd_if.cmd == CMD_RUN)) begin
            state_reg <= ST_RUN;
          end else if (cmd_accept && (cmd_if.cmd == CMD_STEP)) begin
            state_reg <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (halt_take) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= NB_DRAIN'(DRAIN_CYCLES);
          end else if (cmd_accept && (cmd_if.cmd == CMD_STOP)) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_STEP: begin
          if (halt_take) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= NB_DRAIN'(DRAIN_CYCLES);
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          drain_cnt_reg <= drain_cnt_reg - NB_DRAIN'(1);
          if (drain_cnt_reg == NB_DRAIN'(1)) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (cmd_accept && (cmd_if.cmd == CMD_CLEAR)) begin
            state_reg     <= ST_IDLE;
            done_reg      <= 1'b0;
            cycle_cnt_reg <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_if.cmd_ready = cmd_ready;
  assign o_state          = state_reg;
  assign o_done           = done_reg;
  assign o_cycle_count    = cycle_cnt_reg;

endmodule
